gmii_frame_gen: RTL and testbench
=================================

GMII_FRAME_GEN -- requirements
Module: gmii_frame_gen

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12: idle (dv=0) cycles after each frame.
REQ-002 SHALL have parameter MIN_LEN, default 46: minimum payload bytes; shorter payloads are padded.
REQ-003 SHALL have parameter MAX_LEN, default 1500: maximum payload bytes; longer requests are clamped.
REQ-004 SHALL have ports:
- clk_clk in 1: single clock.
- reset_reset_n in 1: reset, asynchronous, active-low.
- start in 1: one-cycle launch request.
- len in 11: requested payload byte count.
- dst_mac in 48: destination address.
- src_mac in 48: source address.
- ethertype in 16: type/length field.
- seed in 8: first payload byte.
- err_inject in 1: corrupt the frame under test.
- gmii_rx_d out 8, gmii_rx_dv out 1, gmii_rx_err out 1: GMII receive bus into the TSE MAC gmii_rx_* inputs.
- busy out 1: frame or IFG in progress.
- done out 1: one-cycle end-of-frame pulse.
- frame_cnt out 16: frames completed.

Function
REQ-005 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored.
REQ-006 SHALL capture all inputs on the accept cycle N (len, dst_mac, src_mac, ethertype, seed, err_inject); busy SHALL be 1 from N+1.
REQ-007 SHALL drive the first preamble byte with dv=1 at N+1.
REQ-008 SHALL use states IDLE->PRE->SFD->DST->SRC->TYPE->PAY->PAD->FCS->IFG->IDLE.
REQ-009 PRE SHALL send 7x 0x55; SFD SHALL send 1x 0xD5.
REQ-010 DST, SRC and TYPE SHALL be sent MSB byte first.
REQ-011 PAY SHALL send seed, seed+1, ..., incrementing mod 256, for L=min(len,MAX_LEN) bytes.
REQ-012 If L<MIN_LEN, PAD SHALL send MIN_LEN-L bytes of 0x00; otherwise PAD SHALL be skipped.
REQ-013 len=0 SHALL produce a fully padded frame.
REQ-014 FCS SHALL send CRC-32 over DST..PAD: reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement, LS byte first.
REQ-015 gmii_rx_dv SHALL be 1 exactly from the first PRE byte through the last FCS byte.
REQ-016 IFG SHALL hold dv=0 and d=0x00 for IFG_BYTES cycles.
REQ-017 done SHALL pulse in the last IFG cycle; busy SHALL be 0 in the following cycle, and start SHALL be accepted in that cycle.
REQ-018 frame_cnt SHALL increment with done and wrap 0xFFFF->0x0000.
REQ-019 If err_inject was captured, gmii_rx_err SHALL be 1 for the first PAY (or PAD) byte only; data and CRC SHALL be unaffected.
REQ-020 Outside REQ-019, gmii_rx_err SHALL be 0.
REQ-021 gmii_rx_d SHALL be 0x00 whenever dv=0.

Reset
REQ-022 Asserting reset_reset_n=0 at any time, mid-frame included, SHALL immediately force IDLE and gmii_rx_d=0, dv=0, err=0, busy=0, done=0, frame_cnt=0; no partial frame SHALL resume.
REQ-023 The first start SHALL be accepted on the first rising edge after deassertion.

Configuration
REQ-024 With GMII_FRAME_GEN_CRC_EN defined, SHALL implement FCS per REQ-014.
REQ-025 Without GMII_FRAME_GEN_CRC_EN, SHALL skip the FCS state (PAY/PAD->IFG), frames SHALL be 4 bytes shorter, and no CRC logic SHALL be present.

Structure
REQ-026 SHALL place in package gmii_frame_gen_pkg: state enum, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY 0xEDB88320, CRC_INIT 0xFFFFFFFF.
REQ-027 SHALL use sub-module crc32_d8 (8-bit/cycle CRC update with clear and enable), instantiated only under GMII_FRAME_GEN_CRC_EN.

Verification
REQ-028 crc32_d8 unit: bytes "123456789" (0x31..0x39) -> complemented result 0xCBF43926.
REQ-029 len=46, seed=0x00, dst=FF..FF, src=00:11:22:33:44:55, type=0x0800 -> dv high 72 cycles; payload 0x00..0x2D; FCS matches the software model; dv low 12 cycles; done once; frame_cnt=1.
REQ-030 len=10 -> 10 payload bytes then 36x 0x00 pad; dv high 72 cycles.
REQ-031 len=2000 -> 1500 payload bytes; dv high 1526 cycles.
REQ-032 start held high continuously for 3 frames -> back-to-back frames separated by exactly 12 idle cycles; frame_cnt=3.
REQ-033 Reset asserted at payload byte 20 -> outputs 0 within the same cycle, no done pulse; next start yields a clean frame.
REQ-034 err_inject=1 -> gmii_rx_err high for exactly one cycle at the first payload byte.

Source files
------------

// File: rtl/gmii_frame_gen_pkg.sv
// Shared types and constants for the GMII receive-side frame generator.
// CRC helper used by crc32_d8 (present only with GMII_FRAME_GEN_CRC_EN).
package gmii_frame_gen_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PRE,
      S_SFD,
      S_DST,
      S_SRC,
      S_TYPE,
      S_PAY,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

   // One byte of reflected CRC-32, LSB of the data first.
   function automatic logic [31:0] crc32_step(
      input logic [31:0] crc,
      input logic [7:0]  data
   );
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = {1'b0, c[31:1]} ^ (CRC_POLY & {32{c[0] ^ data[i]}});
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register with synchronous clear and enable.
// Holds the raw (uncomplemented) remainder; callers invert for the FCS.
module crc32_d8
   import gmii_frame_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // Next remainder: clear wins over update.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = crc32_step(crc_q, data);
      end
   end

   // Remainder register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII frame generator feeding a MAC's gmii_rx_* inputs.
// Define GMII_FRAME_GEN_CRC_EN to append a CRC-32 FCS to every frame.
module gmii_frame_gen #(
   parameter int IFG_BYTES = 12,
   parameter int MIN_LEN   = 46,
   parameter int MAX_LEN   = 1500
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        start,
   input  logic [10:0] len,
   input  logic [47:0] dst_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] ethertype,
   input  logic [7:0]  seed,
   input  logic        err_inject,
   output logic [7:0]  gmii_rx_d,
   output logic        gmii_rx_dv,
   output logic        gmii_rx_err,
   output logic        busy,
   output logic        done,
   output logic [15:0] frame_cnt
);

   import gmii_frame_gen_pkg::*;

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);
   // The accept cycle in IDLE is the final idle byte of the gap.
   localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 2);
`ifdef GMII_FRAME_GEN_CRC_EN
   localparam state_t S_TAIL = S_FCS;
`else
   localparam state_t S_TAIL = S_IFG;
`endif

   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [10:0] len_q, len_d;
   logic [47:0] dst_q, dst_d;
   logic [47:0] src_q, src_d;
   logic [15:0] type_q, type_d;
   logic [7:0]  pay_q, pay_d;
   logic        err_q, err_d;
   logic [15:0] fcnt_q, fcnt_d;

   logic        pad_need;
   logic [10:0] pad_last;

   assign pad_need = len_q < MIN_L;
   assign pad_last = MIN_L - len_q - 11'd1;

`ifdef GMII_FRAME_GEN_CRC_EN
   logic [31:0] crc_w;
   logic        crc_clr;
   logic        crc_en;

   assign crc_clr = (state_q == S_SFD);
   assign crc_en  = state_q inside {S_DST, S_SRC, S_TYPE, S_PAY, S_PAD};

   crc32_d8 u_crc (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .clr   (crc_clr),
      .en    (crc_en),
      .data  (gmii_rx_d),
      .crc   (crc_w)
   );
`endif

   // Next state, byte counters and the GMII byte for the current state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 11'd1;
      len_d       = len_q;
      dst_d       = dst_q;
      src_d       = src_q;
      type_d      = type_q;
      pay_d       = pay_q;
      err_d       = err_q;
      fcnt_d      = fcnt_q;
      gmii_rx_d   = 8'h00;
      gmii_rx_dv  = 1'b0;
      gmii_rx_err = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = 11'd0;
            if (start) begin
               state_d = S_PRE;
               len_d   = (len > MAX_L) ? MAX_L : len;
               dst_d   = dst_mac;
               src_d   = src_mac;
               type_d  = ethertype;
               pay_d   = seed;
               err_d   = err_inject;
            end
         end
         S_PRE: begin
            gmii_rx_dv = 1'b1;
            gmii_rx_d  = PREAMBLE_BYTE;
            if (cnt_q == 11'd6) begin
               state_d = S_SFD;
               cnt_d   = 11'd0;
            end
         end
         S_SFD: begin
            gmii_rx_dv = 1'b1;
            gmii_rx_d  = SFD_BYTE;
            state_d    = S_DST;
            cnt_d      = 11'd0;
         end
         S_DST: begin
            gmii_rx_dv = 1'b1;
            gmii_rx_d  = dst_q[47:40];
            dst_d      = {dst_q[39:0], 8'h00};
            if (cnt_q == 11'd5) begin
               state_d = S_SRC;
               cnt_d   = 11'd0;
            end
         end
         S_SRC: begin
            gmii_rx_dv = 1'b1;
            gmii_rx_d  = src_q[47:40];
            src_d      = {src_q[39:0], 8'h00};
            if (cnt_q == 11'd5) begin
               state_d = S_TYPE;
               cnt_d   = 11'd0;
            end
         end
         S_TYPE: begin
            gmii_rx_dv = 1'b1;
            gmii_rx_d  = type_q[15:8];
            type_d     = {type_q[7:0], 8'h00};
            if (cnt_q == 11'd1) begin
               cnt_d = 11'd0;
               if (len_q != 11'd0) state_d = S_PAY;
               else if (pad_need)  state_d = S_PAD;
               else                state_d = S_TAIL;
            end
         end
         S_PAY: begin
            gmii_rx_dv  = 1'b1;
            gmii_rx_d   = pay_q;
            gmii_rx_err = err_q && (cnt_q == 11'd0);
            pay_d       = pay_q + 8'd1;
            if (cnt_q == len_q - 11'd1) begin
               cnt_d   = 11'd0;
               state_d = pad_need ? S_PAD : S_TAIL;
            end
         end
         S_PAD: begin
            gmii_rx_dv  = 1'b1;
            gmii_rx_err = err_q && (cnt_q == 11'd0)
                          && (len_q == 11'd0);
            if (cnt_q == pad_last) begin
               cnt_d   = 11'd0;
               state_d = S_TAIL;
            end
         end
         S_FCS: begin
`ifdef GMII_FRAME_GEN_CRC_EN
            gmii_rx_dv = 1'b1;
            gmii_rx_d  = ~crc_w[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q == 11'd3) begin
               state_d = S_IFG;
               cnt_d   = 11'd0;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_IFG: begin
            if (cnt_q == IFG_LAST) begin
               done    = 1'b1;
               state_d = S_IDLE;
               cnt_d   = 11'd0;
               fcnt_d  = fcnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and captured frame parameters.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 11'd0;
         len_q   <= 11'd0;
         dst_q   <= 48'd0;
         src_q   <= 48'd0;
         type_q  <= 16'd0;
         pay_q   <= 8'd0;
         err_q   <= 1'b0;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         type_q  <= type_d;
         pay_q   <= pay_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Scoreboard bench for gmii_frame_gen and the crc32_d8 unit.
// Frame expectations adapt to GMII_FRAME_GEN_CRC_EN.
module tb_gmii_frame_gen;

   localparam int IFG  = 12;
   localparam int MINL = 46;
   localparam int MAXL = 1500;
`ifdef GMII_FRAME_GEN_CRC_EN
   localparam int FCS_N = 4;
`else
   localparam int FCS_N = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] len = '0;
   logic [47:0] dst_mac = '0;
   logic [47:0] src_mac = '0;
   logic [15:0] ethertype = '0;
   logic [7:0]  seed = '0;
   logic        err_inject = 1'b0;
   logic [7:0]  rx_d;
   logic        rx_dv;
   logic        rx_err;
   logic        busy;
   logic        done;
   logic [15:0] frame_cnt;

   logic        c_clr = 1'b0;
   logic        c_en = 1'b0;
   logic [7:0]  c_data = '0;
   logic [31:0] c_crc;

   int n_cmp = 0;
   int n_bad = 0;
   int done_n = 0;
   int idle_bad = 0;
   int run_len = 0;
   int gap_len = 0;
   bit seen = 0;
   int fc_exp = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   int         run_q[$];
   int         gap_q[$];

   always #5 clk = ~clk;

   gmii_frame_gen #(
      .IFG_BYTES (IFG),
      .MIN_LEN   (MINL),
      .MAX_LEN   (MAXL)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .start         (start),
      .len           (len),
      .dst_mac       (dst_mac),
      .src_mac       (src_mac),
      .ethertype     (ethertype),
      .seed          (seed),
      .err_inject    (err_inject),
      .gmii_rx_d     (rx_d),
      .gmii_rx_dv    (rx_dv),
      .gmii_rx_err   (rx_err),
      .busy          (busy),
      .done          (done),
      .frame_cnt     (frame_cnt)
   );

   crc32_d8 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (c_clr),
      .en    (c_en),
      .data  (c_data),
      .crc   (c_crc)
   );

   // Monitor: record bytes, dv run lengths, idle gaps, done pulses.
   always @(negedge clk) begin
      if (!rst_n) begin
         run_len = 0;
         gap_len = 0;
         seen = 0;
      end else begin
         if (done) done_n++;
         if (rx_dv) begin
            obs_q.push_back({rx_err, rx_d});
            run_len++;
            if (seen && gap_len != 0) gap_q.push_back(gap_len);
            gap_len = 0;
            seen = 1;
         end else begin
            if (run_len != 0) run_q.push_back(run_len);
            run_len = 0;
            gap_len++;
            if (rx_d !== 8'h00 || rx_err !== 1'b0) idle_bad++;
         end
      end
   end

   function automatic logic [31:0] crc_upd(
      input logic [31:0] c,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) begin
         if (r[0]) r = (r >> 1) ^ 32'hEDB88320;
         else      r = r >> 1;
      end
      return r;
   endfunction

   // Reference frame: pushes expected {err,byte} and returns dv length.
   function automatic int push_frame(
      input int          l_req,
      input logic [47:0] d,
      input logic [47:0] s,
      input logic [15:0] t,
      input logic [7:0]  sd,
      input bit          e
   );
      logic [8:0]  body[$];
      logic [31:0] c;
      int          l;
      l = (l_req > MAXL) ? MAXL : l_req;
      for (int i = 0; i < 6; i++) body.push_back({1'b0, d[47-8*i -: 8]});
      for (int i = 0; i < 6; i++) body.push_back({1'b0, s[47-8*i -: 8]});
      for (int i = 0; i < 2; i++) body.push_back({1'b0, t[15-8*i -: 8]});
      for (int i = 0; i < l; i++)
         body.push_back({e && i == 0, sd + 8'(i)});
      for (int i = 0; i < MINL - l; i++)
         body.push_back({e && l == 0 && i == 0, 8'h00});
      c = 32'hFFFFFFFF;
      foreach (body[i]) c = crc_upd(c, body[i][7:0]);
      c = ~c;
      if (FCS_N == 4)
         for (int i = 0; i < 4; i++) body.push_back({1'b0, c[8*i +: 8]});
      for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
      exp_q.push_back(9'h0D5);
      foreach (body[i]) exp_q.push_back(body[i]);
      return 8 + body.size();
   endfunction

   // Walk both queues, report the first differing byte, then empty them.
   function automatic void diff_frames(
      output int         nb,
      output int         idx,
      output logic [8:0] got,
      output logic [8:0] want
   );
      nb = 0;
      idx = -1;
      got = '0;
      want = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [8:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 9'bx;
         if (o !== exp_q[i]) begin
            if (idx < 0) begin
               idx = i;
               got = o;
               want = exp_q[i];
            end
            nb++;
         end
      end
      if (obs_q.size() != exp_q.size()) nb++;
      exp_q.delete();
      obs_q.delete();
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic launch(
      input int          l,
      input logic [47:0] d,
      input logic [47:0] s,
      input logic [15:0] t,
      input logic [7:0]  sd,
      input bit          e
   );
      len = 11'(l);
      dst_mac = d;
      src_mac = s;
      ethertype = t;
      seed = sd;
      err_inject = e;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(
      input  int target,
      input  int budget,
      output bit ok
   );
      ok = 0;
      for (int i = 0; i < budget && done_n < target; i++) tick();
      if (done_n >= target) ok = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      n_cmp++;
      if ({rx_d, rx_dv, rx_err} !== 10'd0) begin
         n_bad++;
         $display("FAIL reset_gmii: got %h want 000", {rx_d, rx_dv, rx_err});
      end
      n_cmp++;
      if ({busy, done, frame_cnt} !== 18'd0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %h want 0", {busy, done, frame_cnt});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_min_frame();
      int el, nb, ix, rl;
      logic [8:0] g, w;
      bit ok;
      int d0;
      d0 = done_n;
      run_q.delete();
      el = push_frame(46, 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455,
                      16'h0800, 8'h00, 0);
      launch(46, 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455,
             16'h0800, 8'h00, 0);
      n_cmp++;
      if ({busy, rx_dv, rx_d} !== {2'b11, 8'h55}) begin
         n_bad++;
         $display("FAIL min_first: got %h want 355", {busy, rx_dv, rx_d});
      end
      wait_done(d0 + 1, 300, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL min_timeout: got %0d dones want %0d", done_n - d0, 1);
      end
      tick();
      fc_exp++;
      n_cmp++;
      if ({busy, frame_cnt} !== {1'b0, 16'(fc_exp)}) begin
         n_bad++;
         $display("FAIL min_cnt: got %h want %h", {busy, frame_cnt},
                  {1'b0, 16'(fc_exp)});
      end
      n_cmp++;
      if (done_n - d0 != 1) begin
         n_bad++;
         $display("FAIL min_done: got %0d want 1", done_n - d0);
      end
      rl = (run_q.size() > 0) ? run_q.pop_front() : -1;
      n_cmp++;
      if (rl != el || el != 68 + FCS_N) begin
         n_bad++;
         $display("FAIL min_dv_len: got %0d want %0d", rl, 68 + FCS_N);
      end
      diff_frames(nb, ix, g, w);
      n_cmp++;
      if (nb != 0) begin
         n_bad++;
         $display("FAIL min_data: %0d bad, byte %0d got %h want %h",
                  nb, ix, g, w);
      end
   endtask

   task automatic test_pad_ignore();
      int el, nb, ix, rl;
      logic [8:0] g, w;
      bit ok;
      int d0;
      d0 = done_n;
      run_q.delete();
      el = push_frame(10, 48'h0102_0304_0506, 48'hA0A1_A2A3_A4A5,
                      16'h88B5, 8'h7E, 0);
      launch(10, 48'h0102_0304_0506, 48'hA0A1_A2A3_A4A5,
             16'h88B5, 8'h7E, 0);
      repeat (20) tick();
      launch(3, 48'h0, 48'h0, 16'h0, 8'h33, 1);
      wait_done(d0 + 1, 300, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL pad_timeout: got %0d dones want 1", done_n - d0);
      end
      repeat (30) tick();
      fc_exp++;
      n_cmp++;
      if (done_n - d0 != 1 || frame_cnt !== 16'(fc_exp)) begin
         n_bad++;
         $display("FAIL pad_ignore: got %0d/%0d want 1/%0d",
                  done_n - d0, frame_cnt, fc_exp);
      end
      rl = (run_q.size() > 0) ? run_q.pop_front() : -1;
      n_cmp++;
      if (rl != el || run_q.size() != 0) begin
         n_bad++;
         $display("FAIL pad_dv_len: got %0d want %0d", rl, el);
      end
      diff_frames(nb, ix, g, w);
      n_cmp++;
      if (nb != 0) begin
         n_bad++;
         $display("FAIL pad_data: %0d bad, byte %0d got %h want %h",
                  nb, ix, g, w);
      end
   endtask

   task automatic test_max_clamp();
      int el, nb, ix, rl;
      logic [8:0] g, w;
      bit ok;
      int d0;
      d0 = done_n;
      run_q.delete();
      el = push_frame(2000, 48'h0A0B_0C0D_0E0F, 48'h1234_5678_9ABC,
                      16'h86DD, 8'hF0, 0);
      launch(2000, 48'h0A0B_0C0D_0E0F, 48'h1234_5678_9ABC,
             16'h86DD, 8'hF0, 0);
      wait_done(d0 + 1, 2000, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL max_timeout: got %0d dones want 1", done_n - d0);
      end
      tick();
      fc_exp++;
      rl = (run_q.size() > 0) ? run_q.pop_front() : -1;
      n_cmp++;
      if (rl != el || el != 1522 + FCS_N) begin
         n_bad++;
         $display("FAIL max_dv_len: got %0d want %0d", rl, 1522 + FCS_N);
      end
      diff_frames(nb, ix, g, w);
      n_cmp++;
      if (nb != 0) begin
         n_bad++;
         $display("FAIL max_data: %0d bad, byte %0d got %h want %h",
                  nb, ix, g, w);
      end
   endtask

   task automatic test_back_to_back();
      int el, nb, ix;
      logic [8:0] g, w;
      bit ok;
      int d0, f0;
      d0 = done_n;
      f0 = fc_exp;
      run_q.delete();
      gap_q.delete();
      for (int i = 0; i < 3; i++)
         el = push_frame(46, 48'hDEAD_BEEF_0001, 48'h0200_0000_0001,
                         16'h0806, 8'h10, 0);
      len = 11'd46;
      dst_mac = 48'hDEAD_BEEF_0001;
      src_mac = 48'h0200_0000_0001;
      ethertype = 16'h0806;
      seed = 8'h10;
      err_inject = 1'b0;
      start = 1'b1;
      wait_done(d0 + 3, 600, ok);
      start = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL b2b_timeout: got %0d dones want 3", done_n - d0);
      end
      repeat (40) tick();
      fc_exp += 3;
      n_cmp++;
      if (frame_cnt !== 16'(fc_exp) || fc_exp - f0 != 3) begin
         n_bad++;
         $display("FAIL b2b_cnt: got %0d want %0d", frame_cnt, fc_exp);
      end
      n_cmp++;
      if (gap_q.size() != 3 || gap_q[1] != IFG || gap_q[2] != IFG) begin
         n_bad++;
         $display("FAIL b2b_gap: got %0d gaps, %0d/%0d want 3, %0d/%0d",
                  gap_q.size(), (gap_q.size() > 1) ? gap_q[1] : -1,
                  (gap_q.size() > 2) ? gap_q[2] : -1, IFG, IFG);
      end
      n_cmp++;
      if (run_q.size() != 3 || run_q[0] != el || run_q[2] != el) begin
         n_bad++;
         $display("FAIL b2b_runs: got %0d runs want 3 of %0d",
                  run_q.size(), el);
      end
      diff_frames(nb, ix, g, w);
      n_cmp++;
      if (nb != 0) begin
         n_bad++;
         $display("FAIL b2b_data: %0d bad, byte %0d got %h want %h",
                  nb, ix, g, w);
      end
   endtask

   task automatic test_err_inject();
      int el, nb, ix, ne;
      logic [8:0] g, w;
      bit ok;
      int d0;
      int lens[2] = '{5, 0};
      for (int t = 0; t < 2; t++) begin
         d0 = done_n;
         el = push_frame(lens[t], 48'h0000_5E00_0001, 48'h00AA_BBCC_DDEE,
                         16'h0800, 8'h80, 1);
         launch(lens[t], 48'h0000_5E00_0001, 48'h00AA_BBCC_DDEE,
                16'h0800, 8'h80, 1);
         wait_done(d0 + 1, 300, ok);
         tick();
         fc_exp++;
         ne = 0;
         foreach (obs_q[i]) if (obs_q[i][8]) ne++;
         n_cmp++;
         if (!ok || ne != 1 || obs_q.size() < 23 || obs_q[22][8] !== 1'b1) begin
            n_bad++;
            $display("FAIL err_pulse%0d: got %0d err bytes want 1 at 22",
                     t, ne);
         end
         diff_frames(nb, ix, g, w);
         n_cmp++;
         if (nb != 0 || el != 68 + FCS_N) begin
            n_bad++;
            $display("FAIL err_data%0d: %0d bad, byte %0d got %h want %h",
                     t, nb, ix, g, w);
         end
      end
   endtask

   task automatic test_reset_mid();
      int el, nb, ix, rl;
      logic [8:0] g, w;
      bit ok;
      int d0, n;
      d0 = done_n;
      el = push_frame(100, 48'h1111_2222_3333, 48'h4444_5555_6666,
                      16'h0800, 8'h00, 0);
      launch(100, 48'h1111_2222_3333, 48'h4444_5555_6666,
             16'h0800, 8'h00, 0);
      n = 0;
      while (obs_q.size() < 43 && n < 200) begin
         tick();
         n++;
      end
      n_cmp++;
      if (obs_q.size() != 43 || rx_d !== 8'd20) begin
         n_bad++;
         $display("FAIL rstmid_reach: got %0d bytes d=%h want 43 d=14",
                  obs_q.size(), rx_d);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rx_d, rx_dv, rx_err, busy, done, frame_cnt} !== 28'd0) begin
         n_bad++;
         $display("FAIL rstmid_outs: got %h want 0",
                  {rx_d, rx_dv, rx_err, busy, done, frame_cnt});
      end
      repeat (3) tick();
      n_cmp++;
      if (done_n != d0 || frame_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL rstmid_done: got %0d/%0d want 0/0",
                  done_n - d0, frame_cnt);
      end
      exp_q.delete();
      obs_q.delete();
      run_q.delete();
      fc_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      el = push_frame(46, 48'h7766_5544_3322, 48'h0011_2233_4455,
                      16'h0800, 8'h05, 0);
      launch(46, 48'h7766_5544_3322, 48'h0011_2233_4455,
             16'h0800, 8'h05, 0);
      wait_done(d0 + 1, 300, ok);
      tick();
      fc_exp++;
      rl = (run_q.size() > 0) ? run_q.pop_front() : -1;
      n_cmp++;
      if (!ok || rl != el || frame_cnt !== 16'(fc_exp)) begin
         n_bad++;
         $display("FAIL rstmid_clean: got len %0d cnt %0d want %0d/%0d",
                  rl, frame_cnt, el, fc_exp);
      end
      diff_frames(nb, ix, g, w);
      n_cmp++;
      if (nb != 0) begin
         n_bad++;
         $display("FAIL rstmid_data: %0d bad, byte %0d got %h want %h",
                  nb, ix, g, w);
      end
   endtask

   task automatic test_crc_unit();
      logic [31:0] ref_c;
      c_clr = 1'b1;
      tick();
      c_clr = 1'b0;
      n_cmp++;
      if (c_crc !== 32'hFFFFFFFF) begin
         n_bad++;
         $display("FAIL crc_clear: got %h want ffffffff", c_crc);
      end
      ref_c = 32'hFFFFFFFF;
      c_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         c_data = 8'h31 + 8'(i);
         ref_c = crc_upd(ref_c, c_data);
         tick();
      end
      c_en = 1'b0;
      n_cmp++;
      if (~c_crc !== 32'hCBF43926 || ~ref_c !== 32'hCBF43926) begin
         n_bad++;
         $display("FAIL crc_check: got %h want cbf43926", ~c_crc);
      end
   endtask

   initial begin
      test_reset();
      test_min_frame();
      test_pad_ignore();
      test_max_clamp();
      test_back_to_back();
      test_err_inject();
      test_reset_mid();
      test_crc_unit();
      n_cmp++;
      if (idle_bad != 0) begin
         n_bad++;
         $display("FAIL idle_bus: got %0d dirty idle cycles want 0", idle_bad);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
